// File: rtl/arcade_input_router.sv
// Player-input router: merges UserIO DB joysticks ahead of USB joysticks, shapes
// each player's coin button into a timed pulse and qualifies a held OSD combo.
module arcade_input_router #(
  parameter int NUM_PLAYERS = 2,
  parameter int BTN_W = 16,
  parameter int COIN_BIT = 10,
  parameter int CLK_HZ = 12000000,
  parameter int COIN_MS = 50,
  parameter int COIN_GAP_MS = 50,
  parameter int OSD_HOLD_MS = 500,
  parameter logic [BTN_W-1:0] OSD_MASK = 16'h0440
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NUM_PLAYERS*BTN_W-1:0] joy_usb,
  input  logic [2*BTN_W-1:0]           joy_db,
  input  logic                         db_ena,
  input  logic                         db_two,
  output logic [NUM_PLAYERS*BTN_W-1:0] joy_out,
  output logic [BTN_W-1:0]             joy_any,
  output logic [NUM_PLAYERS-1:0]       coin_busy,
  output logic                         osd_req,
  output logic                         ms_tick
);

  localparam int DIV  = CLK_HZ / 1000;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CMAX = (COIN_MS > COIN_GAP_MS) ? COIN_MS : COIN_GAP_MS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(OSD_HOLD_MS + 1);

  localparam logic [PW-1:0]    PRE_MAX  = PW'(DIV - 1);
  localparam logic [CW-1:0]    C_PULSE  = CW'(COIN_MS);
  localparam logic [CW-1:0]    C_GAP    = CW'(COIN_GAP_MS);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(OSD_HOLD_MS);
  localparam logic [BTN_W-1:0] COIN_M   = BTN_W'(1) << COIN_BIT;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_WREL} coin_state_t;

  // 1 ms prescaler
  logic [PW-1:0] pre;

  always_ff @(posedge clk_sys) begin
    if (reset || pre == PRE_MAX) pre <= '0;
    else                         pre <= pre + 1'b1;
  end

  assign ms_tick = (pre == PRE_MAX);

  // ext[0..1] are the DB words, ext[2..] the USB words; routing picks a window.
  logic [BTN_W-1:0] ext [NUM_PLAYERS+2];
  logic [BTN_W-1:0] src [NUM_PLAYERS];
  logic [BTN_W-1:0] out_w [NUM_PLAYERS];
  logic [1:0]       n_db;

  assign n_db   = db_ena ? (db_two ? 2'd2 : 2'd1) : 2'd0;
  assign ext[0] = joy_db[0 +: BTN_W];
  assign ext[1] = joy_db[BTN_W +: BTN_W];

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_usb
    assign ext[i+2] = joy_usb[i*BTN_W +: BTN_W];
  end

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_player
    coin_state_t      st;
    logic [CW-1:0]    cnt;
    logic [BTN_W-1:0] word_q;
    logic             c;

    assign src[k] = (n_db == 2'd2) ? ext[k] :
                    (n_db == 2'd1) ? ((k == 0) ? ext[0] : ext[k+1]) :
                                     ext[k+2];
    assign c = src[k][COIN_BIT];

    // Shaper keeps its state across source switches; c simply follows src.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        st     <= S_IDLE;
        cnt    <= '0;
        word_q <= '0;
      end else begin
        word_q <= src[k] & ~COIN_M;
        case (st)
          S_IDLE: begin
            if (c) begin
              st  <= S_PULSE;
              cnt <= C_PULSE;
            end
          end
          S_PULSE: begin
            if (ms_tick) begin
              if (cnt > CW'(1)) cnt <= cnt - 1'b1;
              else begin
                st  <= S_GAP;
                cnt <= C_GAP;
              end
            end
          end
          S_GAP: begin
            if (ms_tick) begin
              if (cnt > CW'(1)) cnt <= cnt - 1'b1;
              else begin
                st  <= S_WREL;
                cnt <= '0;
              end
            end
          end
          S_WREL: begin
            if (!c) st <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end

    assign out_w[k]                   = word_q | ((st == S_PULSE) ? COIN_M : '0);
    assign joy_out[k*BTN_W +: BTN_W]  = out_w[k];
    assign coin_busy[k]               = (st != S_IDLE);
  end

  always_comb begin
    joy_any = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) joy_any = joy_any | out_w[k];
  end

  // OSD combo hold counter, saturating at HOLD_MAX
  logic [HW-1:0] hold;
  logic          combo;

  assign combo = db_ena && ((ext[0] & OSD_MASK) == OSD_MASK);

  always_ff @(posedge clk_sys) begin
    if (reset || !combo) begin
      hold    <= '0;
      osd_req <= 1'b0;
    end else if (ms_tick && hold != HOLD_MAX) begin
      hold    <= hold + 1'b1;
      osd_req <= (hold + 1'b1 == HOLD_MAX);
    end
  end

endmodule

// File: tb/tb_arcade_input_router.sv
// Bench for arcade_input_router: directed scenarios plus random traffic, all
// outputs compared every cycle against a tick-counting reference model.
module tb_arcade_input_router;

  localparam int NP   = 2;
  localparam int BW   = 16;
  localparam int CB   = 10;
  localparam int DIV  = 12;
  localparam int CMS  = 3;
  localparam int CGAP = 2;
  localparam int HOLD = 4;
  localparam logic [15:0] MASK = 16'h0440;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] joy_usb = '0;
  logic [31:0] joy_db  = '0;
  logic        db_ena  = 1'b0;
  logic        db_two  = 1'b0;
  logic [31:0] joy_out;
  logic [15:0] joy_any;
  logic [1:0]  coin_busy;
  logic        osd_req;
  logic        ms_tick;

  arcade_input_router #(
    .NUM_PLAYERS(NP), .BTN_W(BW), .COIN_BIT(CB), .CLK_HZ(12000),
    .COIN_MS(CMS), .COIN_GAP_MS(CGAP), .OSD_HOLD_MS(HOLD), .OSD_MASK(MASK)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .joy_usb(joy_usb), .joy_db(joy_db),
    .db_ena(db_ena), .db_two(db_two), .joy_out(joy_out), .joy_any(joy_any),
    .coin_busy(coin_busy), .osd_req(osd_req), .ms_tick(ms_tick)
  );

  // clock / watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model: counts ms ticks since reset, pulses defined by tick distance
  int   m_cyc, m_ticks, m_hold;
  bit   m_act [2];
  int   m_acc [2];
  logic [15:0] e_any;
  logic [1:0]  e_busy;
  logic        e_osd, e_tick;
  bit          edge_had_tick;

  task automatic model_step();
    logic [15:0] words[$];
    logic [15:0] src [2];
    logic [31:0] e_out;
    bit tick_e, c, coin;
    bit started [2];
    if (reset) begin
      m_cyc = 0; m_ticks = 0; m_hold = 0;
      for (int k = 0; k < NP; k++) begin m_act[k] = 0; m_acc[k] = 0; end
      exp_q.push_back('0);
      e_any = '0; e_busy = '0; e_osd = 1'b0; e_tick = 1'b0;
      return;
    end
    tick_e = (m_cyc % DIV == DIV - 1);
    m_cyc++;
    words = {};
    if (db_ena) begin
      words.push_back(joy_db[15:0]);
      if (db_two) words.push_back(joy_db[31:16]);
    end
    words.push_back(joy_usb[15:0]);
    words.push_back(joy_usb[31:16]);
    for (int k = 0; k < NP; k++) begin
      src[k] = words[k];
      started[k] = 0;
      c = src[k][CB];
      if (m_act[k]) begin
        if ((m_ticks - m_acc[k]) >= CMS + CGAP && !c) m_act[k] = 0;
      end else if (c) begin
        m_act[k] = 1;
        started[k] = 1;
      end
    end
    if (tick_e) m_ticks++;
    e_any = '0;
    for (int k = 0; k < NP; k++) begin
      if (started[k]) m_acc[k] = m_ticks;
      coin = m_act[k] && ((m_ticks - m_acc[k]) < CMS);
      e_out[k*16 +: 16] = (src[k] & ~16'h0400) | (coin ? 16'h0400 : 16'h0000);
      e_any = e_any | e_out[k*16 +: 16];
      e_busy[k] = m_act[k];
    end
    if (!(db_ena && ((joy_db[15:0] & MASK) == MASK))) m_hold = 0;
    else if (tick_e && m_hold < HOLD) m_hold++;
    e_osd  = (m_hold == HOLD);
    e_tick = (m_cyc % DIV == DIV - 1);
    exp_q.push_back(e_out);
  endtask

  task automatic check_all();
    logic [31:0] e;
    e = exp_q.pop_front();
    check("joy_out",   64'(joy_out),   64'(e));
    check("joy_any",   64'(joy_any),   64'(e_any));
    check("coin_busy", 64'(coin_busy), 64'(e_busy));
    check("osd_req",   64'(osd_req),   64'(e_osd));
    check("ms_tick",   64'(ms_tick),   64'(e_tick));
  endtask

  // driver tasks
  task automatic cycle();
    model_step();
    edge_had_tick = ms_tick;
    @(posedge clk_sys);
    #1;
    check_all();
  endtask

  task automatic wait_coin(input logic val, input int bound, input string tag);
    int g = 0;
    while (joy_out[CB] !== val && g < bound) begin cycle(); g++; end
    check(tag, 64'(joy_out[CB]), 64'(val));
  endtask

  task automatic count_rises(input int n, output int rises);
    logic prev;
    prev = joy_out[CB];
    rises = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (joy_out[CB] && !prev) rises++;
      prev = joy_out[CB];
    end
  endtask

  initial begin
    int first, second, len, rises, n, g;
    logic prev;

    // reset and tick cadence
    repeat (3) cycle();
    check("rst_joy_out", 64'(joy_out), 64'(0));
    check("rst_joy_any", 64'(joy_any), 64'(0));
    check("rst_busy",    64'(coin_busy), 64'(0));
    reset = 1'b0;
    first = -1; second = -1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (ms_tick && first < 0) first = i;
      else if (ms_tick && second < 0) second = i;
    end
    check("first_tick", 64'(first), 64'(11));
    check("tick_period", 64'(second - first), 64'(12));

    // routing
    joy_usb = 32'h0102_0005;
    cycle();
    check("route_usb", 64'(joy_out), 64'(32'h0102_0005));
    check("any_usb",   64'(joy_any), 64'(16'h0107));
    db_ena = 1'b1; joy_db = 32'h0000_0008; joy_usb = 32'h0000_0001;
    cycle();
    check("route_db1", 64'(joy_out), 64'(32'h0001_0008));
    db_two = 1'b1; joy_db = 32'h0020_0008;
    cycle();
    check("route_db2", 64'(joy_out), 64'(32'h0020_0008));

    // coin pulse while held
    db_ena = 1'b0; db_two = 1'b0; joy_db = '0; joy_usb = '0;
    repeat (5) cycle();
    joy_usb = 32'h0000_0400;
    len = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (joy_out[CB]) len++;
      if (joy_out[CB] && !prev) rises++;
      prev = joy_out[CB];
    end
    check("coin_len_25_36", 64'(len >= 25 && len <= 36), 64'(1));
    check("coin_one_pulse", 64'(rises), 64'(1));
    check("coin_busy_held", 64'(coin_busy[0]), 64'(1));
    joy_usb = '0;
    cycle(); cycle();
    check("coin_idle", 64'(coin_busy[0]), 64'(0));

    // re-press during gap is ignored, press after idle pulses again
    joy_usb = 32'h0000_0400;
    wait_coin(1'b1, 5, "coin2_rise");
    wait_coin(1'b0, 40, "coin2_fall");
    joy_usb = '0;
    cycle();
    joy_usb = 32'h0000_0400;
    count_rises(40, rises);
    check("gap_repress", 64'(rises), 64'(0));
    joy_usb = '0;
    cycle(); cycle();
    joy_usb = 32'h0000_0400;
    count_rises(5, rises);
    check("repress_idle", 64'(rises), 64'(1));

    // OSD hold qualification
    joy_usb = '0; db_ena = 1'b1; db_two = 1'b0; joy_db = 32'h0000_0440;
    g = 0;
    while (!osd_req && g < 80) begin cycle(); g++; end
    check("osd_rise", 64'(osd_req), 64'(1));
    joy_db = 32'h0000_0400;
    cycle();
    check("osd_break", 64'(osd_req), 64'(0));
    joy_db = 32'h0000_0440;
    n = 0; g = 0;
    while (n < 3 && g < 100) begin cycle(); if (edge_had_tick) n++; g++; end
    check("osd_hold3", 64'(osd_req), 64'(0));
    while (n < 4 && g < 100) begin cycle(); if (edge_had_tick) n++; g++; end
    check("osd_hold4", 64'(osd_req), 64'(1));

    // reset in mid-pulse
    db_ena = 1'b0; joy_db = '0; joy_usb = '0;
    repeat (3) cycle();
    joy_usb = 32'h0000_0400;
    wait_coin(1'b1, 5, "rst_pulse_rise");
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check("rst_mid_coin", 64'(joy_out[CB]), 64'(0));
    check("rst_mid_busy", 64'(coin_busy), 64'(0));
    reset = 1'b0;
    cycle();
    check("rst_repulse_busy", 64'(coin_busy[0]), 64'(1));
    check("rst_repulse_coin", 64'(joy_out[CB]), 64'(1));

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      reset = 1'b0;
      if (r < 30) joy_usb = ($urandom() & 32'hFBFF_FBFF) | (joy_usb & 32'h0400_0400);
      else if (r < 38) joy_usb[$urandom_range(0, 1) * 16 + CB] = ~joy_usb[$urandom_range(0, 1) * 0 + CB + 0];
      else if (r < 43) begin
        joy_db = $urandom();
        if ($urandom_range(0, 1) == 1) joy_db[15:0] = joy_db[15:0] | MASK;
      end
      else if (r < 46) db_ena = ~db_ena;
      else if (r < 48) db_two = ~db_two;
      else if (r == 99 && $urandom_range(0, 9) == 0) reset = 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
